// File: rtl/rr_grant_arbiter.sv
// Round-robin consumer for N bypass FIFOs: grants one requester per cycle,
// captures its beat a cycle later into a 2-entry buffer, streams it out.
module rr_grant_arbiter #(
    parameter  int N     = 3,
    parameter  int WIDTH = 64,
    localparam int SW    = $clog2(N)
) (
    input  logic                 CLK,
    input  logic                 Reset,
    input  logic [N-1:0]         i_Req,
    output logic [N-1:0]         o_Grant,
    input  logic [N-1:0]         i_Valid,
    input  logic [N*WIDTH-1:0]   i_Data,
    output logic                 o_Valid,
    output logic [WIDTH-1:0]     o_Data,
    output logic [SW-1:0]        o_Src,
    input  logic                 i_Ready,
    output logic                 o_ProtoErr
);

    logic [SW-1:0]    ptr_r;
    logic [SW-1:0]    src_r;
    logic             inflight_r;
    logic [1:0]       count_r;
    logic [WIDTH-1:0] head_data_r;
    logic [WIDTH-1:0] tail_data_r;
    logic [SW-1:0]    head_src_r;
    logic [SW-1:0]    tail_src_r;

    logic             pop_s;
    logic             push_s;
    logic             grant_ok_s;
    logic [2:0]       occ_s;
    logic             found_s;
    logic [SW-1:0]    grant_idx_s;
    logic [N-1:0]     grant_s;
    logic [WIDTH-1:0] cap_data_s;

    function automatic logic [SW-1:0] wrap_idx(input logic [SW-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= N) begin
            sum = sum - N;
        end else begin
            sum = sum;
        end
        return SW'(sum);
    endfunction

    // Credit check: beats already held or on their way must leave room for this grant.
    assign pop_s      = o_Valid & i_Ready;
    assign occ_s      = {1'b0, count_r} + {2'b00, inflight_r} - {2'b00, pop_s};
    assign grant_ok_s = (occ_s <= 3'd1);
    assign push_s     = inflight_r & i_Valid[src_r];
    assign cap_data_s = i_Data[src_r*WIDTH +: WIDTH];

    // Round-robin search starting at ptr_r, wrapping modulo N.
    always_comb begin
        found_s     = 1'b0;
        grant_idx_s = '0;
        grant_s     = '0;
        for (int i = 0; i < N; i++) begin
            if (!found_s && i_Req[wrap_idx(ptr_r, i)]) begin
                found_s     = 1'b1;
                grant_idx_s = wrap_idx(ptr_r, i);
            end else begin
                found_s = found_s;
            end
        end
        if (found_s && grant_ok_s && !Reset) begin
            grant_s[grant_idx_s] = 1'b1;
        end else begin
            grant_s = '0;
        end
    end

    assign o_Grant    = grant_s;
    assign o_ProtoErr = inflight_r & ~i_Valid[src_r];
    assign o_Valid    = (count_r != 2'd0);
    assign o_Data     = head_data_r;
    assign o_Src      = head_src_r;

    // Arbitration pointer and record of the grant whose beat arrives next cycle.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            ptr_r      <= '0;
            src_r      <= '0;
            inflight_r <= 1'b0;
        end else begin
            inflight_r <= |grant_s;
            if (|grant_s) begin
                ptr_r <= wrap_idx(grant_idx_s, 1);
                src_r <= grant_idx_s;
            end
        end
    end

    // Two-entry in-order output buffer; head is always the presented beat.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            count_r     <= 2'd0;
            head_data_r <= '0;
            tail_data_r <= '0;
            head_src_r  <= '0;
            tail_src_r  <= '0;
        end else begin
            case ({push_s, pop_s})
                2'b10: begin
                    if (count_r == 2'd0) begin
                        head_data_r <= cap_data_s;
                        head_src_r  <= src_r;
                    end else begin
                        tail_data_r <= cap_data_s;
                        tail_src_r  <= src_r;
                    end
                    count_r <= count_r + 2'd1;
                end
                2'b01: begin
                    head_data_r <= tail_data_r;
                    head_src_r  <= tail_src_r;
                    count_r     <= count_r - 2'd1;
                end
                2'b11: begin
                    if (count_r == 2'd1) begin
                        head_data_r <= cap_data_s;
                        head_src_r  <= src_r;
                    end else begin
                        head_data_r <= tail_data_r;
                        head_src_r  <= tail_src_r;
                        tail_data_r <= cap_data_s;
                        tail_src_r  <= src_r;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Scoreboard bench for rr_grant_arbiter: source FIFOs are modelled in tick(),
// expected beats queue up when presented and are compared when popped.
module tb_rr_grant_arbiter;
    localparam int N     = 3;
    localparam int WIDTH = 64;
    localparam int SW    = 2;

    logic               CLK = 1'b0;
    logic               Reset = 1'b0;
    logic [N-1:0]       i_Req = '0;
    logic [N-1:0]       o_Grant;
    logic [N-1:0]       i_Valid = '0;
    logic [N*WIDTH-1:0] i_Data = '0;
    logic               o_Valid;
    logic [WIDTH-1:0]   o_Data;
    logic [SW-1:0]      o_Src;
    logic               i_Ready = 1'b0;
    logic               o_ProtoErr;

    int n_checks = 0;
    int n_fail   = 0;

    logic [SW+WIDTH-1:0] exp_q[$];
    int           seq[N];
    int           pend = 0;
    logic         perr_exp = 1'b0;
    logic [N-1:0] prev_grant = '0;
    logic [N-1:0] last_grant = '0;
    logic         last_valid = 1'b0;
    logic         last_perr = 1'b0;
    bit           drop_next = 1'b0;
    bit           noise = 1'b0;

    rr_grant_arbiter #(.N(N), .WIDTH(WIDTH)) dut (
        .CLK(CLK), .Reset(Reset), .i_Req(i_Req), .o_Grant(o_Grant),
        .i_Valid(i_Valid), .i_Data(i_Data), .o_Valid(o_Valid), .o_Data(o_Data),
        .o_Src(o_Src), .i_Ready(i_Ready), .o_ProtoErr(o_ProtoErr)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [WIDTH-1:0] mk_data(input int k, input int s);
        return {16'hA5A5, 16'(k), 32'(s)};
    endfunction

    task automatic clear_model();
        exp_q.delete();
        pend       = 0;
        perr_exp   = 1'b0;
        prev_grant = '0;
        drop_next  = 1'b0;
        noise      = 1'b0;
        i_Valid    = '0;
        for (int k = 0; k < N; k++) seq[k] = 0;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        clear_model();
        repeat (2) @(posedge CLK);
        #1 Reset = 1'b0;
    endtask

    // One clock: observe at negedge, then act as the granted source after posedge.
    task automatic tick();
        int cnt_m, infl_m, pop_m, k;
        logic [WIDTH-1:0] d;
        logic [SW+WIDTH-1:0] e;
        @(negedge CLK);
        last_grant = o_Grant;
        last_valid = o_Valid;
        last_perr  = o_ProtoErr;
        cnt_m  = exp_q.size() - pend;
        infl_m = (prev_grant != '0) ? 1 : 0;
        pop_m  = (o_Valid && i_Ready) ? 1 : 0;
        n_checks++;
        if (o_Valid !== (cnt_m > 0)) begin
            n_fail++;
            $display("FAIL valid: got %b want %b at %0t", o_Valid, (cnt_m > 0), $time);
        end
        n_checks++;
        if (o_ProtoErr !== perr_exp) begin
            n_fail++;
            $display("FAIL proto_err: got %b want %b at %0t", o_ProtoErr, perr_exp, $time);
        end
        n_checks++;
        if ($countones(o_Grant) > 1 || (o_Grant != '0 && (cnt_m + infl_m - pop_m) > 1)) begin
            n_fail++;
            $display("FAIL grant_credit: got grant %b with count %0d inflight %0d pop %0d", o_Grant, cnt_m, infl_m, pop_m);
        end
        if (pop_m == 1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL beat_extra: got src %0d data %h want no beat", o_Src, o_Data);
            end else begin
                e = exp_q.pop_front();
                if ({o_Src, o_Data} !== e) begin
                    n_fail++;
                    $display("FAIL beat: got src %0d data %h want src %0d data %h", o_Src, o_Data, e[SW+WIDTH-1:WIDTH], e[WIDTH-1:0]);
                end
            end
        end
        prev_grant = o_Grant;
        @(posedge CLK);
        #1;
        pend     = 0;
        perr_exp = 1'b0;
        i_Valid  = {N{noise}};
        for (int j = 0; j < N; j++) i_Data[j*WIDTH +: WIDTH] = {32'hDEADBEEF, 32'(j)};
        if (last_grant != '0) begin
            k = 0;
            for (int j = 0; j < N; j++) if (last_grant[j]) k = j;
            if (drop_next) begin
                i_Valid[k] = 1'b0;
                perr_exp   = 1'b1;
            end else begin
                d = mk_data(k, seq[k]);
                seq[k]++;
                i_Valid[k] = 1'b1;
                i_Data[k*WIDTH +: WIDTH] = d;
                exp_q.push_back({SW'(k), d});
                pend = 1;
            end
        end
        drop_next = 1'b0;
    endtask

    task automatic drain();
        i_Req   = '0;
        i_Ready = 1'b1;
        repeat (4) tick();
        n_checks++;
        if (exp_q.size() != 0 || last_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drain: got %0d beats left valid %b want 0 beats valid 0", exp_q.size(), last_valid);
        end
    endtask

    task automatic test_reset();
        i_Req = 3'b111;
        #1 Reset = 1'b1;
        #1;
        n_checks++;
        if (o_Grant !== 3'b000 || o_Valid !== 1'b0 || o_ProtoErr !== 1'b0 || o_Data !== 64'd0 || o_Src !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_state: got grant %b valid %b perr %b data %h src %0d want all zero", o_Grant, o_Valid, o_ProtoErr, o_Data, o_Src);
        end
        clear_model();
        repeat (2) @(posedge CLK);
        #1 Reset = 1'b0;
        tick();
        n_checks++;
        if (last_grant !== 3'b001) begin
            n_fail++;
            $display("FAIL reset_first_grant: got %b want 001", last_grant);
        end
        drain();
    endtask

    task automatic test_single();
        int first_valid = -1;
        int nvalid = 0;
        do_reset();
        i_Req   = 3'b010;
        i_Ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_checks++;
            if (last_grant !== 3'b010) begin
                n_fail++;
                $display("FAIL single_grant: cycle %0d got %b want 010", i, last_grant);
            end
            if (last_valid) begin
                nvalid++;
                if (first_valid < 0) first_valid = i;
            end
        end
        n_checks++;
        if (first_valid != 2 || nvalid != 6) begin
            n_fail++;
            $display("FAIL single_latency: got first valid %0d count %0d want 2 and 6", first_valid, nvalid);
        end
        drain();
    endtask

    task automatic test_fairness();
        int cnt[N];
        logic [N-1:0] exp_g;
        do_reset();
        for (int k = 0; k < N; k++) cnt[k] = 0;
        i_Req   = 3'b111;
        i_Ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            exp_g = 3'b001 << (i % N);
            n_checks++;
            if (last_grant !== exp_g) begin
                n_fail++;
                $display("FAIL fair_grant: cycle %0d got %b want %b", i, last_grant, exp_g);
            end
            for (int k = 0; k < N; k++) if (last_grant[k]) cnt[k]++;
        end
        n_checks++;
        if (cnt[0] != 4 || cnt[1] != 4 || cnt[2] != 4) begin
            n_fail++;
            $display("FAIL fair_share: got %0d/%0d/%0d want 4/4/4", cnt[0], cnt[1], cnt[2]);
        end
        drain();
    endtask

    task automatic test_backpressure();
        logic [N-1:0] bp_exp [6] = '{3'b001, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000};
        do_reset();
        i_Req   = 3'b111;
        i_Ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_checks++;
            if (last_grant !== bp_exp[i]) begin
                n_fail++;
                $display("FAIL bp_grant: cycle %0d got %b want %b", i, last_grant, bp_exp[i]);
            end
        end
        n_checks++;
        if (o_Valid !== 1'b1 || o_Src !== 2'd0 || o_Data !== mk_data(0, 0)) begin
            n_fail++;
            $display("FAIL bp_hold: got valid %b src %0d data %h want 1 0 %h", o_Valid, o_Src, o_Data, mk_data(0, 0));
        end
        i_Ready = 1'b1;
        tick();
        n_checks++;
        if (last_grant !== 3'b100) begin
            n_fail++;
            $display("FAIL bp_resume: got %b want 100", last_grant);
        end
        repeat (3) tick();
        drain();
    endtask

    task automatic test_proto_err();
        do_reset();
        i_Req     = 3'b100;
        i_Ready   = 1'b1;
        noise     = 1'b1;
        drop_next = 1'b1;
        tick();
        n_checks++;
        if (last_grant !== 3'b100) begin
            n_fail++;
            $display("FAIL perr_grant: got %b want 100", last_grant);
        end
        i_Req = 3'b000;
        tick();
        n_checks++;
        if (last_perr !== 1'b1 || last_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL perr_pulse: got perr %b valid %b want 1 0", last_perr, last_valid);
        end
        tick();
        n_checks++;
        if (last_perr !== 1'b0 || last_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL perr_clear: got perr %b valid %b want 0 0", last_perr, last_valid);
        end
        i_Req = 3'b111;
        tick();
        n_checks++;
        if (last_grant !== 3'b001) begin
            n_fail++;
            $display("FAIL perr_ptr: got %b want 001", last_grant);
        end
        noise = 1'b0;
        drain();
    endtask

    task automatic test_wrap_skip();
        logic [N-1:0] reqs [3] = '{3'b010, 3'b011, 3'b011};
        logic [N-1:0] exps [3] = '{3'b010, 3'b001, 3'b010};
        do_reset();
        i_Ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            i_Req = reqs[i];
            tick();
            n_checks++;
            if (last_grant !== exps[i]) begin
                n_fail++;
                $display("FAIL wrap_grant: step %0d got %b want %b", i, last_grant, exps[i]);
            end
        end
        drain();
    endtask

    task automatic test_async_reset();
        do_reset();
        i_Req   = 3'b111;
        i_Ready = 1'b0;
        tick();
        tick();
        #2;
        n_checks++;
        if (o_Valid !== 1'b1) begin
            n_fail++;
            $display("FAIL areset_pre: got valid %b want 1", o_Valid);
        end
        Reset = 1'b1;
        #1;
        n_checks++;
        if (o_Valid !== 1'b0 || o_Grant !== 3'b000 || o_ProtoErr !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_now: got valid %b grant %b perr %b want 0 000 0", o_Valid, o_Grant, o_ProtoErr);
        end
        clear_model();
        repeat (2) @(posedge CLK);
        #1 Reset = 1'b0;
        i_Ready = 1'b1;
        tick();
        n_checks++;
        if (last_grant !== 3'b001) begin
            n_fail++;
            $display("FAIL areset_grant: got %b want 001", last_grant);
        end
        drain();
    endtask

    initial begin
        for (int k = 0; k < N; k++) seq[k] = 0;
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_proto_err();
        test_wrap_skip();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
